alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: N, 64, operand/result width; only 64 is supported.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  in  N  requester 0 operands.
REQ-007 req0_op  in  4  requester 0 ALUControl code.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op: same as REQ-004..007, for requester 1.
REQ-009 rsp_valid  out  1  response register holds a result.
REQ-010 rsp_ready  in  1  consumer accepts the response.
REQ-011 rsp_id  out  1  index of the requester that issued the response.
REQ-012 rsp_result  out  N  ALU result.
REQ-013 rsp_zero  out  1  high when rsp_result is zero.

Function
REQ-014 The block SHALL contain one shared combinational ALU and a single-entry response register, with states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-015 ALU op codes: 0000 a AND b; 0001 a OR b; 0010 a+b; 0110 a-b; 0111 pass b; 1100 NOR(a,b). Any other code passes a.
REQ-016 Add/sub SHALL wrap modulo 2^64 with no carry or overflow output; e.g. FFFF_FFFF_FFFF_FFFF + A = 9.
REQ-017 accept = !rsp_valid | rsp_ready; reqX_ready SHALL be 1 only for the granted requester, and only when accept=1.
REQ-018 reqX_ready SHALL depend combinationally on the valids, the pointer, rsp_valid and rsp_ready. It SHALL NOT depend on reqX_ready itself.
REQ-019 Transfer occurs on a cycle with reqX_valid & reqX_ready. At the next rising edge the response register loads result, zero and id, and rsp_valid=1; latency is 1 cycle.
REQ-020 Drain occurs on rsp_valid & rsp_ready. A drain with no transfer in the same cycle SHALL go FULL->EMPTY.
REQ-021 A drain and a transfer in the same cycle SHALL load the new result and keep rsp_valid=1; throughput is 1 op/cycle.
REQ-022 While FULL and rsp_ready=0, all rsp_* outputs SHALL hold stable and both reqX_ready SHALL be 0.
REQ-023 A requester SHALL keep valid, operands and op stable until its ready is seen. The block SHALL NOT sample a non-transferred request.
REQ-024 Arbitration SHALL follow the selection in REQ-031/032. Only one requester SHALL be ready in any cycle.
REQ-025 The priority pointer SHALL update only on a transfer, to point away from the requester just served.
REQ-026 No request SHALL starve: with both valid and rsp_ready=1, grants alternate 0,1,0,1 (round-robin build).

Reset
REQ-027 On reset low, immediately: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, and the pointer favours requester 0.
REQ-028 Reset asserted mid-operation SHALL discard any held response without delivering it. Both ready outputs SHALL be 0 while reset is low.
REQ-029 After reset deasserts, the block SHALL accept a request on the first clock edge.

Configuration
REQ-030 Macro ALU_ARBITER_RR_EN selects the arbitration policy.
REQ-031 With ALU_ARBITER_RR_EN defined: round-robin per REQ-025/026.
REQ-032 Without ALU_ARBITER_RR_EN: fixed priority, requester 0 always wins, no pointer register, and requester 1 may starve.

Verification
REQ-033 Single op: req0 sends a=AAAA_AAAA_AAAA_AAAA, b=0000_0000_FFFF_FFFF, op=0000, with rsp_ready=1. Next cycle: rsp_valid=1, rsp_result=0000_0000_AAAA_AAAA, rsp_zero=0, rsp_id=0.
REQ-034 Contention (RR build): both valid; req0 op=0010 a=0123_4567 b=89AB_CDEF; req1 op=0110 a=b=CCCC_CCCC_CCCC_CCCC. Expect first 8ACF_1356 with id 0, then 0 with zero=1 and id 1, then alternating grants.
REQ-035 Backpressure: hold rsp_ready=0 while FULL for 5 cycles. rsp_* stable and both ready=0; on rsp_ready=1, back-to-back ops complete 1/cycle.
REQ-036 Default/pass: op=1010 with a=0 and b=FFFF_FFFF_FFFF_FFFF gives result 0 and zero=1. op=0111 with the same operands gives FFFF_FFFF_FFFF_FFFF.
REQ-037 Reset mid-op: assert reset while FULL and unread. rsp_valid drops to 0 with no clock edge, and the first grant after release goes to req0.
REQ-038 Fixed-priority build: both valid for 4 cycles with rsp_ready=1. All 4 grants go to req0 (rsp_id=0).

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared 64-bit ALU with a single-entry response register.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_zero
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0110,
    OP_PASSB = 4'b0111,
    OP_NOR  = 4'b1100
  } alu_op_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

  rsp_state_e   state;
  logic         grant_any;
  logic         grant_id;
  logic         accept;
  logic         xfer;
  logic [N-1:0] sel_a;
  logic [N-1:0] sel_b;
  logic [3:0]   sel_op;
  logic [N-1:0] alu_result;

`ifdef ALU_ARBITER_RR_EN
  // Requester favoured when both are valid; 0 after reset.
  logic ptr;
`endif

  // Unlisted op codes fall through to pass-a.
  function automatic logic [N-1:0] alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic [3:0] op);
    case (op)
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_PASSB: return b;
      OP_NOR:   return ~(a | b);
      default:  return a;
    endcase
  endfunction

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
`ifdef ALU_ARBITER_RR_EN
    if (req0_valid && req1_valid) begin
      grant_any = 1'b1;
      grant_id  = ptr;
    end else if (req0_valid) begin
      grant_any = 1'b1;
      grant_id  = 1'b0;
    end else if (req1_valid) begin
      grant_any = 1'b1;
      grant_id  = 1'b1;
    end
`else
    if (req0_valid) begin
      grant_any = 1'b1;
      grant_id  = 1'b0;
    end else if (req1_valid) begin
      grant_any = 1'b1;
      grant_id  = 1'b1;
    end
`endif
  end

  assign rsp_valid  = (state == FULL);
  assign accept     = !rsp_valid || rsp_ready;
  // Readies are gated by reset so nothing is offered while the block is held in reset.
  assign xfer       = reset && accept && grant_any;
  assign req0_ready = xfer && !grant_id;
  assign req1_ready = xfer && grant_id;

  assign sel_a      = grant_id ? req1_a  : req0_a;
  assign sel_b      = grant_id ? req1_b  : req0_b;
  assign sel_op     = grant_id ? req1_op : req0_op;
  assign alu_result = alu(sel_a, sel_b, sel_op);

  // NOTE: sequential state is written only with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
`ifdef ALU_ARBITER_RR_EN
      ptr        <= 1'b0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (xfer) state <= FULL;
        end
        FULL: begin
          if (!xfer && rsp_ready) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
      if (xfer) begin
        rsp_id     <= grant_id;
        rsp_result <= alu_result;
        rsp_zero   <= (alu_result == '0);
`ifdef ALU_ARBITER_RR_EN
        ptr        <= ~grant_id;
`endif
      end
    end
  end

  a_one_ready : assert property (@(posedge clk) disable iff (!reset)
    !(req0_ready && req1_ready));

  a_hold_full : assert property (@(posedge clk) disable iff (!reset)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_result) && $stable(rsp_id)
                                   && $stable(rsp_zero)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized traffic against a
// transaction-level reference model. Works for both ALU_ARBITER_RR_EN builds.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [63:0] rsp_result;

  int checks = 0;
  int errors = 0;
  bit rand_mode = 0;

  // Reference model state
  bit          m_valid;
  bit          m_id;
  logic [63:0] m_res;
  bit          m_zero;
  int          m_last;
  bit          m_x0, m_x1;

  alu_arbiter #(.N(64)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b1100: return ~(a | b);
      default: return a;
    endcase
  endfunction

  // Which requester wins this cycle, -1 if none is valid.
  function automatic int pick(input logic v0, input logic v1);
`ifdef ALU_ARBITER_RR_EN
    if (v0 && v1) return (m_last == 0) ? 1 : 0;
`endif
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Compare and advance the model once per cycle, mid-period.
  always @(negedge clk) begin
    bit accept, e0, e1;
    int g;
    if (!reset) begin
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_ready0", req0_ready, 0);
      check("reset_ready1", req1_ready, 0);
      m_valid = 0; m_id = 0; m_res = '0; m_zero = 0; m_last = 1; m_x0 = 0; m_x1 = 0;
    end else begin
      accept = !m_valid || rsp_ready;
      g  = pick(req0_valid, req1_valid);
      e0 = accept && (g == 0);
      e1 = accept && (g == 1);
      check("model_ready0", req0_ready, e0);
      check("model_ready1", req1_ready, e1);
      check("model_rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
        check("model_rsp_id", rsp_id, m_id);
        check("model_rsp_result", rsp_result, m_res);
        check("model_rsp_zero", rsp_zero, m_zero);
      end
      m_x0 = e0;
      m_x1 = e1;
      if (e0 || e1) begin
        m_id    = e1;
        m_res   = e1 ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
        m_zero  = (m_res == 64'd0);
        m_valid = 1;
        m_last  = e1 ? 1 : 0;
      end else if (m_valid && rsp_ready) begin
        m_valid = 0;
      end
    end
  end

  function automatic logic [3:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0110;
      4: return 4'b0111;
      5: return 4'b1100;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [63:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Random requesters only change a request once it has transferred (or was idle).
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      if (!req0_valid || m_x0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_op = rand_op(); req0_a = rand_word();
        req0_b = ($urandom_range(0, 5) == 0) ? req0_a : rand_word();
      end
      if (!req1_valid || m_x1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_op = rand_op(); req1_a = rand_word();
        req1_b = ($urandom_range(0, 5) == 0) ? req1_a : rand_word();
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [63:0] a,
                      input logic [63:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [63:0] a,
                      input logic [63:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  initial begin
    reset = 1'b0;
    rsp_ready = 1'b0;
    set0(0, 4'd0, '0, '0);
    set1(0, 4'd0, '0, '0);
    step(); step();
    check("rst_valid", rsp_valid, 0);
    check("rst_id", rsp_id, 0);
    check("rst_result", rsp_result, 0);
    check("rst_zero", rsp_zero, 0);
    reset = 1'b1;

    // Single AND op, accepted on the first edge after reset release
    set0(1, 4'b0000, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0000_0000_FFFF_FFFF);
    rsp_ready = 1'b1;
    step();
    check("single_valid", rsp_valid, 1);
    check("single_result", rsp_result, 64'h0000_0000_AAAA_AAAA);
    check("single_zero", rsp_zero, 0);
    check("single_id", rsp_id, 0);
    req0_valid = 0;
    step();
    check("single_drained", rsp_valid, 0);

    // Pass/default ops and wraparound add
    set0(1, 4'b1010, 64'd0, '1);
    step();
    check("default_result", rsp_result, 64'd0);
    check("default_zero", rsp_zero, 1);
    set0(1, 4'b0111, 64'd0, '1);
    step();
    check("passb_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("passb_zero", rsp_zero, 0);
    set0(1, 4'b0010, '1, 64'hA);
    step();
    check("wrap_add", rsp_result, 64'd9);
    req0_valid = 0;
    step();

    // Backpressure: hold FULL for 5 cycles, then back-to-back ops
    set0(1, 4'b0010, 64'd1, 64'd2);
    rsp_ready = 1'b0;
    step();
    check("bp_first", rsp_result, 64'd3);
    set0(1, 4'b0001, 64'd4, 64'd8);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_result", rsp_result, 64'd3);
      check("bp_hold_ready0", req0_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_b2b_1", rsp_result, 64'hC);
    set0(1, 4'b0110, 64'd10, 64'd3);
    step();
    check("bp_b2b_2", rsp_result, 64'd7);
    check("bp_b2b_valid", rsp_valid, 1);
    req0_valid = 0;
    step();
    check("bp_drained", rsp_valid, 0);

    // Reset while FULL and unread, then contention
    set0(1, 4'b0010, 64'h0123_4567, 64'h89AB_CDEF);
    rsp_ready = 1'b0;
    step();
    check("pre_reset_full", rsp_valid, 1);
    set1(1, 4'b0110, 64'hCCCC_CCCC_CCCC_CCCC, 64'hCCCC_CCCC_CCCC_CCCC);
    reset = 1'b0;
    #1;
    check("async_reset_valid", rsp_valid, 0);
    check("async_reset_ready0", req0_ready, 0);
    check("async_reset_ready1", req1_ready, 0);
    step();
    reset = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef ALU_ARBITER_RR_EN
      check("rr_id", rsp_id, 1'(i % 2));
      check("rr_result", rsp_result, (i % 2 == 0) ? 64'h8ACF_1356 : 64'd0);
      check("rr_zero", rsp_zero, 1'(i % 2));
`else
      check("fixed_id", rsp_id, 0);
      check("fixed_result", rsp_result, 64'h8ACF_1356);
`endif
    end
    req0_valid = 0;
    req1_valid = 0;
    step();

    // Randomized traffic checked by the model
    rand_mode = 1;
    repeat (3000) @(posedge clk);
    #2;
    rand_mode = 0;
    req0_valid = 0;
    req1_valid = 0;
    rsp_ready = 1;
    step(); step();
    check("final_drained", rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
